// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port numbering and switch-allocator state encoding.
package noc_pkg;
   localparam int NPORTS = 5;
   localparam int PORT_N = 0;
   localparam int PORT_S = 1;
   localparam int PORT_E = 2;
   localparam int PORT_W = 3;
   localparam int PORT_L = 4;

   typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;
endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after ptr, wrapping at N-1.
module rr_picker #(
   parameter int N  = 5,
   parameter int IW = 3
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  onehot,
   output logic [IW-1:0] idx,
   output logic          any
);
   int            c;
   logic [IW-1:0] ci;

   always_comb begin
      onehot = '0;
      idx    = '0;
      any    = 1'b0;
      c      = 0;
      ci     = '0;
      for (int k = 0; k < N; k++) begin
         c = int'(ptr) + k;
         if (c >= N) c = c - N;
         ci = IW'(c);
         if (!any && req[ci]) begin
            any        = 1'b1;
            idx        = ci;
            onehot[ci] = 1'b1;
         end
      end
   end
endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output switch allocator: round-robin grant held for a whole wormhole packet,
// forwarding gated by downstream credits.
module noc_output_arbiter #(
   parameter int NPORTS    = noc_pkg::NPORTS,
   parameter int BUF_DEPTH = 4,
   parameter int CW        = $clog2(BUF_DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NPORTS-1:0] req,
   input  logic [NPORTS-1:0] tail,
   input  logic              credit_in,
   output logic [NPORTS-1:0] grant,
   output logic [2:0]        grant_idx,
   output logic              fwd,
   output logic [CW-1:0]     credits,
   output logic              credit_err
);
   import noc_pkg::*;

   arb_state_t        state, state_nxt;
   logic [NPORTS-1:0] pick_oh;
   logic [2:0]        pick_idx;
   logic              pick_any;
   logic [2:0]        rr_ptr;
   logic              tail_xfer;

   rr_picker #(.N(NPORTS), .IW(3)) u_pick (
      .req    (req),
      .ptr    (rr_ptr),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ARB_IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE:   if (pick_any)  state_nxt = ARB_LOCKED;
         ARB_LOCKED: if (tail_xfer) state_nxt = ARB_IDLE;
         default:    state_nxt = ARB_IDLE;
      endcase
   end

   // fwd is driven straight from the registered owner so the crossbar select is glitch-short
   always_comb begin
      fwd       = (state == ARB_LOCKED) && req[grant_idx] && (credits != '0);
      tail_xfer = fwd && tail[grant_idx];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= '0;
      end else if (state == ARB_IDLE && pick_any) begin
         grant     <= pick_oh;
         grant_idx <= pick_idx;
      end else if (tail_xfer) begin
         grant     <= '0;
         grant_idx <= '0;
         rr_ptr    <= (grant_idx == 3'(NPORTS - 1)) ? 3'd0 : grant_idx + 3'd1;
      end
   end

   // Simultaneous fwd and credit return cancel; a return at full depth is a protocol error.
   always_ff @(posedge clk) begin
      if (rst) begin
         credits    <= CW'(BUF_DEPTH);
         credit_err <= 1'b0;
      end else begin
         case ({fwd, credit_in})
            2'b10: credits <= credits - CW'(1);
            2'b01: begin
               if (credits == CW'(BUF_DEPTH)) credit_err <= 1'b1;
               else                           credits    <= credits + CW'(1);
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/noc_output_arbiter.md
Name: noc_output_arbiter

Overview:
- Per-output-port switch allocator for one mesh router. Five input ports compete for one output direction: N, S, E, W, L (index 0..4).
- Grants the output round-robin and holds the grant for a whole wormhole packet, head flit through tail flit.
- Tracks downstream buffer credits so a flit is forwarded only when the neighbour router (or local sink) has space.
- One instance sits in front of each output port of every router variant. Edge routers tie unused requesters to 0.

Parameters:
- NPORTS, 5, number of requesting input ports.
- BUF_DEPTH, 4, flit slots in the downstream input buffer; initial credit count.
- CW, $clog2(BUF_DEPTH+1), credit counter width.

Ports:
- clk  in  1  router clock (control.clk).
- rst  in  1  synchronous active-high reset (control.rst).
- req  in  NPORTS  req[i]=1: input i presents a flit routed to this output.
- tail  in  NPORTS  tail[i]=1: the flit presented by input i is a tail (single-flit packet: head=tail).
- credit_in  in  1  downstream freed one slot this cycle.
- grant  out  NPORTS  one-hot owner of the output; 0 when idle.
- grant_idx  out  3  binary index of owner; 0 when idle.
- fwd  out  1  the flit of the owner transfers this cycle; crossbar select and downstream write strobe.
- credits  out  CW  current available downstream slots.
- credit_err  out  1  sticky overflow flag.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, grant=0, grant_idx=0, rr_ptr=0, credits=BUF_DEPTH, credit_err=0. fwd=0 while state is IDLE.
- IDLE state:
  - If req!=0, pick the first i with req[i]=1, searching from rr_ptr upward and wrapping at NPORTS-1 to 0.
  - Register grant=onehot(i) and grant_idx=i, then go to LOCKED.
  - Arbitration costs 1 cycle: req rises at edge t, and grant and fwd are visible in cycle t+1.
- LOCKED state:
  - fwd = req[grant_idx] & (credits!=0), combinational from registered state.
  - On fwd & tail[grant_idx]:
    - go to IDLE next cycle;
    - grant clears;
    - rr_ptr = (grant_idx+1) mod NPORTS.
  - On fwd without tail: remain LOCKED.
  - Owner drops req mid-packet (bubble): stay LOCKED, fwd=0. Other requesters are never granted until the tail transfers. Wormhole semantics, no interleaving.
  - credits=0: stay LOCKED, fwd=0 until credit arrives.
- Re-arbitration: the cycle after a tail transfer is IDLE, so there is a 1-cycle gap between packets. Back-to-back packets from the same port are permitted only if no other port requests after rr_ptr.
- Credits:
  - fwd only: decrement.
  - credit_in only: increment.
  - fwd and credit_in in the same cycle: unchanged.
  - credit_in at credits=BUF_DEPTH without fwd: saturate at BUF_DEPTH and set credit_err=1. It stays set until rst.
  - fwd never occurs at credits=0, so there is no underflow.
- Reset mid-packet: the lock is dropped immediately, with no tail required. The credit count returns to BUF_DEPTH. The whole router resets together.
- Unused req bits tied 0 are never granted. rr_ptr may point at them harmlessly.

Decomposition:
- Shared package noc_pkg holds:
  - port index constants PORT_N=0, PORT_S=1, PORT_E=2, PORT_W=3, PORT_L=4;
  - NPORTS;
  - typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t.
- Sub-module rr_picker: a purely combinational priority search from a pointer, returning onehot and index. It is reused later by the VC allocator.
- The credit counter stays inline.

Test Plan:
- Single-flit packet: after reset, req=5'b10000, tail=5'b10000 at cycle 1.
  - Required: grant=5'b10000, grant_idx=4, fwd=1 in cycle 2; credits 4→3.
  - Then IDLE in cycle 3 with grant=0, and rr_ptr=0.
- Round-robin fairness: req=5'b01011 held, every flit a tail, credit_in=1 every cycle.
  - Required: grants rotate idx 0,1,3,0,1,3.
  - grant=0 in each gap cycle, and credits stay at 4 throughout.
- Packet lock: port 1 sends a 3-flit packet while port 0 requests constantly; port 1 drops req for 2 cycles between flit 2 and flit 3.
  - Required: grant stays 5'b00010 with fwd=0 during the bubble.
  - Port 0 is granted only after the tail transfers.
- Credit stall: BUF_DEPTH=4, no credit_in, port 2 sends a 6-flit packet.
  - Required: 4 fwd pulses, credits reach 0, then fwd=0 with the grant held.
  - Pulse credit_in twice: exactly 2 more fwd, the tail releases, and credits end at 0.
- Simultaneous credit and fwd plus overflow:
  - credit_in=1 during fwd at credits=2: credits remain 2.
  - Later, credit_in at credits=4 with no fwd: credits=4 and credit_err=1, sticky until rst.
- Reset mid-packet: assert rst while LOCKED on port 3 with credits=1.
  - Required: next cycle grant=0, fwd=0, credits=4, credit_err=0.
  - The next arbitration starts from rr_ptr=0.
